// File: rtl/instr_decode_pkg.sv
// Shared decode constants: opcodes, one-hot dec bit indices, immediate formats.
// Used by instr_field_decode and instr_decode_stage.
package instr_decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int DEC_LUI    = 0;
    localparam int DEC_AUIPC  = 1;
    localparam int DEC_JALR   = 2;
    localparam int DEC_JAL    = 3;
    localparam int DEC_BRANCH = 4;
    localparam int DEC_STORE  = 5;
    localparam int DEC_LOAD   = 6;
    localparam int DEC_OP_IMM = 7;
    localparam int DEC_OP     = 8;
    localparam int DEC_W      = 9;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational RV32I field decoder: opcode -> one-hot dec, register fields,
// sign-extended immediate and illegal flag.
module instr_field_decode
    import instr_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]  instr,
    output logic [DEC_W-1:0] dec,
    output logic [2:0]       fun_3,
    output logic             fun_7,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [XLEN-1:0]  imm,
    output logic             illegal
);

    imm_fmt_t fmt;

    always_comb begin
        dec = '0;
        fmt = IMM_NONE;
        case (instr[6:0])
            OPC_LUI:    begin dec[DEC_LUI]    = 1'b1; fmt = IMM_U; end
            OPC_AUIPC:  begin dec[DEC_AUIPC]  = 1'b1; fmt = IMM_U; end
            OPC_JALR:   begin dec[DEC_JALR]   = 1'b1; fmt = IMM_I; end
            OPC_JAL:    begin dec[DEC_JAL]    = 1'b1; fmt = IMM_J; end
            OPC_BRANCH: begin dec[DEC_BRANCH] = 1'b1; fmt = IMM_B; end
            OPC_STORE:  begin dec[DEC_STORE]  = 1'b1; fmt = IMM_S; end
            OPC_LOAD:   begin dec[DEC_LOAD]   = 1'b1; fmt = IMM_I; end
            OPC_OP_IMM: begin dec[DEC_OP_IMM] = 1'b1; fmt = IMM_I; end
            OPC_OP:     begin dec[DEC_OP]     = 1'b1; fmt = IMM_NONE; end
            default:    ;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25],
                          instr[11:7]};
            IMM_B: imm = {{(XLEN-12){instr[31]}}, instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
            IMM_J: imm = {{(XLEN-20){instr[31]}}, instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign fun_3   = instr[14:12];
    assign fun_7   = instr[30];
    assign rd      = instr[11:7];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign illegal = (dec == '0) || (instr[1:0] != 2'b11);

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: field decode behind a two-entry skid buffer plus illegal counter.
// DEC_ILLEGAL_TRAP_EN: illegal words raise sticky ill and stall input until ill_clr.
module instr_decode_stage
    import instr_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DEC_W-1:0] dec,
    output logic [2:0]       fun_3,
    output logic             fun_7,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  pc_out,
    output logic             ill,
    input  logic             ill_clr,
    output logic [CNT_W-1:0] ill_cnt
);

    localparam int BW = DEC_W + 3 + 1 + 15 + 2 * XLEN;

    logic [DEC_W-1:0] d_dec;
    logic [2:0]       d_fun_3;
    logic             d_fun_7;
    logic [4:0]       d_rd;
    logic [4:0]       d_rs1;
    logic [4:0]       d_rs2;
    logic [XLEN-1:0]  d_imm;
    logic             d_illegal;

    logic [BW-1:0] in_b;
    logic [BW-1:0] main_q;
    logic [BW-1:0] skid_q;
    logic          main_v;
    logic          skid_v;
    logic          in_fire;
    logic          enq;

    instr_field_decode #(.XLEN(XLEN)) u_fd (
        .instr   (in_instr),
        .dec     (d_dec),
        .fun_3   (d_fun_3),
        .fun_7   (d_fun_7),
        .rd      (d_rd),
        .rs1     (d_rs1),
        .rs2     (d_rs2),
        .imm     (d_imm),
        .illegal (d_illegal)
    );

    assign in_b = {d_dec, d_fun_3, d_fun_7, d_rd, d_rs1, d_rs2,
                   d_imm, in_pc};
    assign in_fire = in_valid && in_ready;

`ifdef DEC_ILLEGAL_TRAP_EN
    logic ill_q;

    assign in_ready = !skid_v && !ill_q;
    assign enq      = in_fire && !d_illegal;
    assign ill      = ill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_q <= 1'b0;
        end else if (in_fire && d_illegal) begin
            ill_q <= 1'b1;
        end else if (ill_clr) begin
            ill_q <= 1'b0;
        end
    end
`else
    logic unused_ill_clr;

    assign unused_ill_clr = ill_clr;
    assign in_ready       = !skid_v;
    assign enq            = in_fire;
    assign ill            = 1'b0;
`endif

    // Skid only fills when main is stalled; it always drains before new input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (!main_v || out_ready) begin
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end else if (enq) begin
                main_q <= in_b;
                main_v <= 1'b1;
            end else begin
                main_v <= 1'b0;
            end
        end else if (enq) begin
            skid_q <= in_b;
            skid_v <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt <= '0;
        end else if (in_fire && d_illegal && ill_cnt != '1) begin
            ill_cnt <= ill_cnt + 1'b1;
        end
    end

    assign out_valid = main_v;
    assign {dec, fun_3, fun_7, rd, rs1, rs2, imm, pc_out} = main_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage; follows DEC_ILLEGAL_TRAP_EN if defined.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  dec;
    logic [2:0]  fun_3;
    logic        fun_7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc_out;
    logic        ill;
    logic        ill_clr;
    logic [7:0]  ill_cnt;

    instr_decode_stage #(.XLEN(32), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dec       (dec),
        .fun_3     (fun_3),
        .fun_7     (fun_7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .pc_out    (pc_out),
        .ill       (ill),
        .ill_clr   (ill_clr),
        .ill_cnt   (ill_cnt)
    );

    always #5 clk = ~clk;

    // Reference: opcode table position gives the dec bit.
    function automatic int opc_class(input logic [31:0] w);
        logic [6:0] tab [9];
        int cls;
        tab = '{7'h37, 7'h17, 7'h67, 7'h6f, 7'h63,
                7'h23, 7'h03, 7'h13, 7'h33};
        cls = -1;
        for (int i = 0; i < 9; i++)
            if (w[6:0] == tab[i]) cls = i;
        return cls;
    endfunction

    function automatic logic [91:0] model(input logic [31:0] w,
                                          input logic [31:0] pc);
        int cls;
        int sw;
        int im;
        logic [8:0] d;
        cls = opc_class(w);
        sw  = $signed(w);
        d   = '0;
        im  = 0;
        if (cls >= 0) d = 9'(1) << cls;
        case (cls)
            0, 1:    im = sw & 32'hFFFFF000;
            2, 6, 7: im = sw >>> 20;
            5:       im = ((sw >>> 25) * 32) + int'(w[11:7]);
            4:       im = ((sw >>> 31) * 4096) + int'(w[7]) * 2048
                          + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            3:       im = ((sw >>> 31) * 1048576)
                          + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                          + int'(w[30:21]) * 2;
            default: im = 0;
        endcase
        return {d, w[14:12], w[30], w[11:7], w[19:15], w[24:20],
                32'(im), pc};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] tab [9];
        logic [31:0] w;
        int pick;
        tab = '{7'h37, 7'h17, 7'h67, 7'h6f, 7'h63,
                7'h23, 7'h03, 7'h13, 7'h33};
        w = $urandom;
`ifdef DEC_ILLEGAL_TRAP_EN
        pick = int'($urandom_range(0, 8));
`else
        pick = int'($urandom_range(0, 9));
`endif
        if (pick < 9) w[6:0] = tab[pick];
        return w;
    endfunction

    logic [91:0] q [$];
    int mchecks = 0;
    int merrs   = 0;
    int dchecks = 0;
    int derrs   = 0;
    logic [31:0] pc = 32'h1000;

    wire [91:0] cur = {dec, fun_3, fun_7, rd, rs1, rs2, imm, pc_out};

    initial begin : monitor
        int exp_cnt;
        logic held_v;
        logic [91:0] held_b;
        logic [91:0] e;
        exp_cnt = 0;
        held_v  = 1'b0;
        held_b  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                exp_cnt = 0;
                held_v  = 1'b0;
            end else begin
                mchecks++;
                if (ill_cnt !== 8'(exp_cnt)) begin
                    merrs++;
                    $display("FAIL ill_cnt: got %0d want %0d",
                             ill_cnt, exp_cnt);
                end
                if (held_v) begin
                    mchecks++;
                    if (!out_valid || cur !== held_b) begin
                        merrs++;
                        $display("FAIL hold: got v=%0b %h want %h",
                                 out_valid, cur, held_b);
                    end
                end
                if (out_valid && out_ready) begin
                    mchecks++;
                    if (q.size() == 0) begin
                        merrs++;
                        $display("FAIL unexpected: got %h want none", cur);
                    end else begin
                        e = q.pop_front();
                        if (cur !== e) begin
                            merrs++;
                            $display("FAIL bundle: got %h want %h", cur, e);
                        end
                    end
                end
                held_v = out_valid && !out_ready;
                held_b = cur;
                if (in_valid && in_ready) begin
                    if (opc_class(in_instr) < 0) begin
                        if (exp_cnt < 255) exp_cnt++;
`ifndef DEC_ILLEGAL_TRAP_EN
                        q.push_back(model(in_instr, in_pc));
`endif
                    end else begin
                        q.push_back(model(in_instr, in_pc));
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        dchecks++;
        if (act !== exp) begin
            derrs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic drive(input logic [31:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        pc       = pc + 4;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("drive_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_check(input logic [31:0] w, input string name,
                              input logic [8:0] e_dec,
                              input logic [31:0] e_imm);
        out_ready = 1'b1;
        drive(w);
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_dec"}, 32'(dec), 32'(e_dec));
        chk({name, "_imm"}, imm, e_imm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        ill_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Mid-stream reset with a stalled legal word and an illegal one.
        drive(32'h00A28293);
        drive(32'h0000007F);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dec", 32'(dec), 32'd0);
        chk("rst_ill_cnt", 32'(ill_cnt), 32'd0);
        chk("rst_ill", 32'(ill), 32'd0);
        chk("rst_imm", imm, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid2", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Streaming, one-cycle latency.
        out_ready = 1'b1;
        drive(32'h00A28293);
        @(negedge clk);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_dec", 32'(dec), 32'h080);
        chk("addi_fun3", 32'(fun_3), 32'd0);
        chk("addi_imm", imm, 32'd10);
        @(posedge clk);
        #1;
        drive(32'h40B50533);
        @(negedge clk);
        chk("sub_dec", 32'(dec), 32'h100);
        chk("sub_fun7", 32'(fun_7), 32'd1);
        chk("sub_rd", 32'(rd), 32'd10);
        @(posedge clk);
        #1;

        // Immediate formats.
        send_check(32'hFE112E23, "sw", 9'h020, 32'hFFFFFFFC);
        send_check(32'hFE000EE3, "beq", 9'h010, 32'hFFFFFFFC);
        send_check(32'h0080006F, "jal", 9'h008, 32'd8);
        send_check(32'h123450B7, "lui", 9'h001, 32'h12345000);

        // Backpressure: two words fill main and skid.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        in_pc     = 32'h2000;
        @(posedge clk);
        #1 in_instr = 32'h00200113;
        in_pc = 32'h2004;
        @(posedge clk);
        #1 in_instr = 32'h00300193;
        in_pc = 32'h2008;
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_hold_pc", pc_out, 32'h2000);
        chk("bp_in_ready2", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 20) begin
                n++;
                @(negedge clk);
            end
            chk("bp_release", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Illegal opcode.
        drive(32'h0000007F);
        @(negedge clk);
`ifdef DEC_ILLEGAL_TRAP_EN
        chk("trap_ill", 32'(ill), 32'd1);
        chk("trap_in_ready", 32'(in_ready), 32'd0);
        chk("trap_cnt", 32'(ill_cnt), 32'd1);
        @(posedge clk);
        #1 ill_clr = 1'b1;
        @(posedge clk);
        #1 ill_clr = 1'b0;
        @(negedge clk);
        chk("trap_clr_ill", 32'(ill), 32'd0);
        chk("trap_clr_ready", 32'(in_ready), 32'd1);
`else
        chk("nop_valid", 32'(out_valid), 32'd1);
        chk("nop_dec", 32'(dec), 32'd0);
        chk("nop_imm", imm, 32'd0);
        chk("nop_ill", 32'(ill), 32'd0);
        chk("nop_cnt", 32'(ill_cnt), 32'd1);
`endif
        @(posedge clk);
        #1;

        // Counter saturation.
        for (int i = 0; i < 300; i++) begin
            drive(32'h0000007F);
`ifdef DEC_ILLEGAL_TRAP_EN
            ill_clr = 1'b1;
            @(posedge clk);
            #1 ill_clr = 1'b0;
`endif
        end
        @(negedge clk);
        chk("cnt_sat", 32'(ill_cnt), 32'd255);
        @(posedge clk);
        #1;

        // Random traffic with random backpressure.
        begin
            logic acc;
            in_valid = 1'b0;
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
                if (!in_valid || acc) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_instr = rand_instr();
                    in_pc    = pc;
                    pc       = pc + 4;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while ((q.size() != 0 || out_valid) && n < 100) begin
                n++;
                @(negedge clk);
            end
        end
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks",
                 derrs + merrs, dchecks + mchecks);
        $finish;
    end

endmodule
